otp_uart_tx: RTL and testbench

//  Transmit side of OTP delivery: takes the 16-bit OTP from the LFSR/FSM path and sends it to the user's

---
 rtl/otp_pkg.sv | 27 ++
 rtl/otp_baud_gen.sv | 30 +++
 rtl/otp_uart_tx.sv | 130 +++++++++++++
 tb/tb_otp_uart_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared definitions for the OTP delivery path: UART FSM encoding, ASCII constants
// and the nibble-to-ASCII helper.
package otp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_NEXT
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    // Uppercase hex only: 0..9 -> '0'..'9', A..F -> 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10)
            return ASCII_0 + {4'd0, nibble};
        else
            return ASCII_A + {4'd0, nibble - 4'd10};
    endfunction

endpackage

// File: rtl/otp_baud_gen.sv
// Bit-period counter for the OTP UART: bit_end marks the last clk of each bit;
// clear restarts the period so every FSM state gets a full bit time.
module otp_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign bit_end = (cnt == LAST);

endmodule

// File: rtl/otp_uart_tx.sv
// Sends a latched OTP as uppercase ASCII hex (MSB nibble first) plus CR LF over 8N1 UART.
// Define OTP_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module otp_uart_tx
    import otp_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_DIGITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] otp,
    input  logic                    otp_valid,
    output logic                    otp_ready,
    output logic                    tx,
    output logic                    busy,
    output logic                    done
);

    localparam int            NUM_CHARS = NUM_DIGITS + 2;
    localparam int            IW        = $clog2(NUM_CHARS);
    localparam logic [IW-1:0] LAST_CHAR = IW'(NUM_CHARS - 1);

    state_t                  state, next_state;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [IW-1:0]           char_idx;
    logic [7:0]              shift_reg;
    logic [2:0]              bit_idx;
    logic                    bit_end;
    logic                    accept;

    // Character idx of a transfer: hex digits MSB first, then CR, then LF.
    function automatic logic [7:0] char_at(input logic [4*NUM_DIGITS-1:0] value,
                                           input logic [IW-1:0] idx);
        logic [4*NUM_DIGITS-1:0] shifted;
        shifted = '0;
        if (int'(idx) < NUM_DIGITS) begin
            shifted = value >> (4 * (NUM_DIGITS - 1 - int'(idx)));
            return hex_to_ascii(shifted[3:0]);
        end else if (int'(idx) == NUM_DIGITS) begin
            return ASCII_CR;
        end else begin
            return ASCII_LF;
        end
    endfunction

    assign accept = otp_valid && (state == S_IDLE);

    otp_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state != state),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every variable written in an always_comb gets a default first,
    // otherwise paths that skip the assignment infer latches.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (accept) next_state = S_START;
            S_START:  if (bit_end) next_state = S_DATA;
`ifdef OTP_TX_PARITY_EN
            S_DATA:   if (bit_end && bit_idx == 3'd7) next_state = S_PARITY;
`else
            S_DATA:   if (bit_end && bit_idx == 3'd7) next_state = S_STOP;
`endif
            S_PARITY: if (bit_end) next_state = S_STOP;
            S_STOP:   if (bit_end) next_state = S_NEXT;
            S_NEXT:   next_state = (char_idx == LAST_CHAR) ? S_IDLE : S_START;
            default:  next_state = S_IDLE;
        endcase
    end

    // Shadow register decouples the transfer from later changes on otp.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '0;
            char_idx  <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (accept) begin
                    shadow    <= otp;
                    char_idx  <= '0;
                    shift_reg <= char_at(otp, '0);
                    bit_idx   <= '0;
                end
                S_DATA: if (bit_end) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 3'd1;
                end
                S_NEXT: if (char_idx != LAST_CHAR) begin
                    char_idx  <= char_idx + IW'(1);
                    shift_reg <= char_at(shadow, char_idx + IW'(1));
                    bit_idx   <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx        = 1'b1;
        otp_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                otp_ready = 1'b1;
                busy      = 1'b0;
            end
            S_START:  tx = 1'b0;
            S_DATA:   tx = shift_reg[0];
`ifdef OTP_TX_PARITY_EN
            S_PARITY: tx = ^char_at(shadow, char_idx);
`endif
            S_NEXT:   done = (char_idx == LAST_CHAR);
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_otp_uart_tx.sv
// Directed bench for otp_uart_tx at CLKS_PER_BIT=4; a mid-bit UART monitor collects bytes.
module tb_otp_uart_tx;

    localparam int CPB = 4;
`ifdef OTP_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int DONE_LAT = 6 * (FRAME_BITS * CPB + 1);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] otp = '0;
    logic        otp_valid = 1'b0;
    logic        otp_ready, tx, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];
    logic       par_q[$];

    otp_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .otp       (otp),
        .otp_valid (otp_valid),
        .otp_ready (otp_ready),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    // Mid-bit sampler: start detected within its first cycle, each later bit sampled one cycle in.
    initial begin : uart_monitor
        logic [7:0] b;
        logic       p;
        bit         abort;
        b = '0;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && tx === 1'b0) begin
                abort = 0;
                @(negedge clk);
                if (reset !== 1'b0 || tx !== 1'b0) abort = 1;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    if (reset !== 1'b0) abort = 1;
                    b[k] = tx;
                end
`ifdef OTP_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (reset !== 1'b0) abort = 1;
                p = tx;
`endif
                repeat (CPB) @(negedge clk);
                if (reset !== 1'b0) abort = 1;
                if (!abort) begin
                    if (tx !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                    par_q.push_back(p);
                end
            end
        end
    end

    task automatic send(input logic [15:0] value, output int acc_cyc);
        @(negedge clk);
        otp       = value;
        otp_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        otp_valid = 1'b0;
    endtask

    // Latency counts edges from the accept edge to the edge that samples done high.
    task automatic wait_done(input int acc_cyc, output int lat, output bit ok);
        ok  = 0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok  = 1;
                lat = cyc - acc_cyc + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (otp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", otp_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1 || otp_ready !== 1'b1) begin
            errors++; $display("FAIL idle_after_reset: got tx=%b ready=%b expected 1 1", tx, otp_ready);
        end
    endtask

    task automatic test_hex_a51f();
        logic [7:0] exp_b [6] = '{8'h41, 8'h35, 8'h31, 8'h46, 8'h0D, 8'h0A};
        int acc, lat;
        bit ok;
        rx_q.delete(); par_q.delete();
        send(16'hA51F, acc);
        @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || otp_ready !== 1'b0) begin
            errors++; $display("FAIL a51f_start: got tx=%b busy=%b ready=%b expected 0 1 0", tx, busy, otp_ready);
        end
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL a51f_latency: got %0d expected %0d", lat, DONE_LAT);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || otp_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL a51f_after_done: got done=%b ready=%b busy=%b expected 0 1 0", done, otp_ready, busy);
        end
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL a51f_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL a51f_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_hex_09f0();
        logic [7:0] exp_b [6] = '{8'h30, 8'h39, 8'h46, 8'h30, 8'h0D, 8'h0A};
        int acc, lat;
        bit ok;
        rx_q.delete(); par_q.delete();
        send(16'h09F0, acc);
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL 09f0_latency: got %0d expected %0d", lat, DONE_LAT);
        end
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL 09f0_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL 09f0_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_ignore_busy_valid();
        logic [7:0] exp_b [6] = '{8'h35, 8'h41, 8'h33, 8'h43, 8'h0D, 8'h0A};
        int acc, lat, d0;
        bit ok;
        rx_q.delete(); par_q.delete();
        send(16'h5A3C, acc);
        d0 = done_cnt;
        repeat (2 * (FRAME_BITS * CPB + 1) + 8) @(negedge clk);
        otp       = 16'h1234;
        otp_valid = 1'b1;
        checks++; if (otp_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", otp_ready); end
        @(negedge clk);
        otp_valid = 1'b0;
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, DONE_LAT);
        end
        repeat (300) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0); end
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL ignore_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL ignore_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp_b [6] = '{8'h30, 8'h39, 8'h46, 8'h30, 8'h0D, 8'h0A};
        int acc, lat, d0;
        bit ok;
        send(16'hA51F, acc);
        d0 = done_cnt;
        repeat (FRAME_BITS * CPB + 1 + CPB + 6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || otp_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got tx=%b ready=%b busy=%b expected 1 1 0", tx, otp_ready, busy);
        end
        repeat (10) @(negedge clk);
        reset = 1'b0;
        rx_q.delete(); par_q.delete();
        repeat (300) @(negedge clk);
        checks++; if (done_cnt !== d0 || rx_q.size() !== 0) begin
            errors++; $display("FAIL midreset_quiet: got done=%0d bytes=%0d expected 0 0", done_cnt - d0, rx_q.size());
        end
        send(16'h09F0, acc);
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, DONE_LAT);
        end
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL midreset_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i]) begin
                errors++; $display("FAIL midreset_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [6] = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
        int acc, acc2, lat;
        bit ok;
        rx_q.delete(); par_q.delete();
        @(negedge clk);
        otp       = 16'hFFFF;
        otp_valid = 1'b1;
        @(posedge clk);
        #1 acc = cyc;
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL b2b_latency1: got %0d expected %0d", lat, DONE_LAT);
        end
        @(negedge clk);
        checks++; if (otp_ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL b2b_gap: got ready=%b busy=%b tx=%b expected 1 0 1", otp_ready, busy, tx);
        end
        @(posedge clk);
        #1 acc2 = cyc;
        otp_valid = 1'b0;
        @(negedge clk);
        checks++; if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_second_start: got tx=%b busy=%b expected 0 1", tx, busy);
        end
        wait_done(acc2, lat, ok);
        checks++; if (!ok || lat !== DONE_LAT) begin
            errors++; $display("FAIL b2b_latency2: got %0d expected %0d", lat, DONE_LAT);
        end
        checks++; if (rx_q.size() !== 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", rx_q.size()); end
        for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i % 6]) begin
                errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_b[i % 6]);
            end
        end
    endtask

`ifdef OTP_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] exp_b [6] = '{8'h31, 8'h41, 8'h30, 8'h30, 8'h0D, 8'h0A};
        logic       exp_p [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int acc, lat;
        bit ok;
        rx_q.delete(); par_q.delete();
        send(16'h1A00, acc);
        wait_done(acc, lat, ok);
        checks++; if (!ok || lat !== 270) begin
            errors++; $display("FAIL parity_latency: got %0d expected 270", lat);
        end
        checks++; if (rx_q.size() !== 6) begin errors++; $display("FAIL parity_count: got %0d expected 6", rx_q.size()); end
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_b[i] || par_q[i] !== exp_p[i]) begin
                errors++; $display("FAIL parity_char%0d: got %h/%b expected %h/%b", i, rx_q[i], par_q[i], exp_b[i], exp_p[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hex_a51f();
        test_hex_09f0();
        test_ignore_busy_valid();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef OTP_TX_PARITY_EN
        test_parity();
`endif
        repeat (50) @(negedge clk);
        checks++; if (frame_err !== 0) begin errors++; $display("FAIL stop_bits: got %0d bad expected 0", frame_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
